// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
// The optional performance counters are enabled with DCACHE_PERF_CNT_EN.
package dcache_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_REFILL    = 2'd2
  } state_t;

  localparam int DEF_NUM_LINES      = 16;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int DEF_OFF_BITS       = $clog2(DEF_WORDS_PER_LINE);
  localparam int DEF_IDX_BITS       = $clog2(DEF_NUM_LINES);
  localparam int DEF_TAG_BITS       = 32 - 2 - DEF_OFF_BITS - DEF_IDX_BITS;

  localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_SAT) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data storage: async read at {index, offset}, sync word write,
// sync fill (tag + valid, dirty cleared), sync dirty set, clear-all on reset.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int IDX_BITS = DEF_IDX_BITS,
  parameter int OFF_BITS = DEF_OFF_BITS,
  parameter int TAG_BITS = DEF_TAG_BITS
) (
  input  logic                clk,
  input  logic                i_srst_n,
  input  logic [IDX_BITS-1:0] i_idx,
  input  logic [OFF_BITS-1:0] i_rd_off,
  output logic [31:0]         o_rd_data,
  output logic [TAG_BITS-1:0] o_tag,
  output logic                o_valid,
  output logic                o_dirty,
  input  logic                i_wr_en,
  input  logic [OFF_BITS-1:0] i_wr_off,
  input  logic [31:0]         i_wr_data,
  input  logic                i_set_dirty,
  input  logic                i_fill,
  input  logic [TAG_BITS-1:0] i_fill_tag
);

  localparam int LINES = 1 << IDX_BITS;
  localparam int WORDS = 1 << OFF_BITS;

  logic [31:0]         r_data [LINES*WORDS];
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [LINES-1:0]    r_valid;
  logic [LINES-1:0]    r_dirty;

  // Data and tags are left unreset; valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (i_srst_n && i_wr_en) begin
      r_data[{i_idx, i_wr_off}] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_srst_n && i_fill) begin
      r_tag[i_idx] <= i_fill_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_srst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_set_dirty) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  assign o_rd_data = r_data[{i_idx, i_rd_off}];
  assign o_tag     = r_tag[i_idx];
  assign o_valid   = r_valid[i_idx];
  assign o_dirty   = r_dirty[i_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache controller with miss FSM and
// word-wide req/ack memory port. DCACHE_PERF_CNT_EN adds hit_cnt/miss_cnt.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rd_en,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int OB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(NUM_LINES);
  localparam int TB = 32 - 2 - OB - IB;
  localparam logic [OB-1:0] LAST_WORD = OB'(WORDS_PER_LINE - 1);

  state_t        r_state, w_state_next;
  logic [OB-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic          r_mem_req, w_mem_req_next;
  logic          r_mem_we, w_mem_we_next;
  logic [31:0]   r_mem_addr, w_mem_addr_next;
  logic [31:0]   r_mem_wdata, w_mem_wdata_next;

  logic          w_access, w_hit, w_ack, w_last;
  logic [OB-1:0] w_off, w_rd_off, w_wr_off;
  logic [IB-1:0] w_idx;
  logic [TB-1:0] w_tag, w_line_tag;
  logic [31:0]   w_line_word, w_wr_data;
  logic          w_line_valid, w_line_dirty;
  logic          w_wr_en, w_set_dirty, w_fill;
  logic          w_unused_ok;

  assign w_off       = cpu_addr[OB+1:2];
  assign w_idx       = cpu_addr[OB+IB+1:OB+2];
  assign w_tag       = cpu_addr[31:OB+IB+2];
  assign w_unused_ok = &{1'b0, cpu_addr[1:0]};

  assign w_access  = cpu_rd_en | cpu_wr_en;
  assign w_hit     = w_line_valid & (w_line_tag == w_tag);
  assign w_ack     = mem_ack & r_mem_req;
  assign w_last    = (r_cnt == LAST_WORD);
  assign w_cnt_inc = r_cnt + OB'(1);

  dcache_line_store #(
    .IDX_BITS(IB),
    .OFF_BITS(OB),
    .TAG_BITS(TB)
  ) u_store (
    .clk        (clk),
    .i_srst_n   (reset),
    .i_idx      (w_idx),
    .i_rd_off   (w_rd_off),
    .o_rd_data  (w_line_word),
    .o_tag      (w_line_tag),
    .o_valid    (w_line_valid),
    .o_dirty    (w_line_dirty),
    .i_wr_en    (w_wr_en),
    .i_wr_off   (w_wr_off),
    .i_wr_data  (w_wr_data),
    .i_set_dirty(w_set_dirty),
    .i_fill     (w_fill),
    .i_fill_tag (w_tag)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_mem_req   <= w_mem_req_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_access && !w_hit) begin
          w_state_next = (w_line_valid && w_line_dirty) ? S_WRITEBACK : S_REFILL;
        end
      end
      S_WRITEBACK: if (w_ack && w_last) w_state_next = S_REFILL;
      S_REFILL:    if (w_ack && w_last) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Request registers are loaded one edge ahead so each word's request is
  // visible the cycle after the previous ack.
  always_comb begin
    w_cnt_next       = r_cnt;
    w_mem_req_next   = r_mem_req;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_rd_off         = w_off;
    w_wr_en          = 1'b0;
    w_wr_off         = w_off;
    w_wr_data        = cpu_wdata;
    w_set_dirty      = 1'b0;
    w_fill           = 1'b0;
    stall            = 1'b0;
    cpu_rdata        = '0;
    case (r_state)
      S_IDLE: begin
        if (w_access && w_hit) begin
          cpu_rdata = w_line_word;
          if (cpu_wr_en) begin
            w_wr_en     = 1'b1;
            w_set_dirty = 1'b1;
          end
        end else if (w_access) begin
          stall          = 1'b1;
          w_rd_off       = '0;
          w_cnt_next     = '0;
          w_mem_req_next = 1'b1;
          if (w_line_valid && w_line_dirty) begin
            w_mem_we_next    = 1'b1;
            w_mem_addr_next  = {w_line_tag, w_idx, {OB{1'b0}}, 2'b00};
            w_mem_wdata_next = w_line_word;
          end else begin
            w_mem_we_next    = 1'b0;
            w_mem_addr_next  = {w_tag, w_idx, {OB{1'b0}}, 2'b00};
            w_mem_wdata_next = '0;
          end
        end
      end
      S_WRITEBACK: begin
        stall    = 1'b1;
        w_rd_off = w_cnt_inc;
        if (w_ack) begin
          if (w_last) begin
            w_cnt_next       = '0;
            w_mem_we_next    = 1'b0;
            w_mem_addr_next  = {w_tag, w_idx, {OB{1'b0}}, 2'b00};
            w_mem_wdata_next = '0;
          end else begin
            w_cnt_next       = w_cnt_inc;
            w_mem_addr_next  = {w_line_tag, w_idx, w_cnt_inc, 2'b00};
            w_mem_wdata_next = w_line_word;
          end
        end
      end
      S_REFILL: begin
        stall     = 1'b1;
        w_wr_off  = r_cnt;
        w_wr_data = mem_rdata;
        if (w_ack) begin
          w_wr_en = 1'b1;
          if (w_last) begin
            w_fill          = 1'b1;
            w_cnt_next      = '0;
            w_mem_req_next  = 1'b0;
            w_mem_we_next   = 1'b0;
            w_mem_addr_next = '0;
          end else begin
            w_cnt_next      = w_cnt_inc;
            w_mem_addr_next = {w_tag, w_idx, w_cnt_inc, 2'b00};
          end
        end
      end
      default: stall = 1'b0;
    endcase
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;
  logic        r_retry;

  // The first IDLE cycle after a refill is the held access retrying, not a new hit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_retry    <= 1'b0;
    end else begin
      r_retry <= (r_state == S_REFILL) && (w_state_next == S_IDLE);
      if (r_state == S_IDLE && w_access) begin
        if (!w_hit) begin
          r_miss_cnt <= sat_inc(r_miss_cnt);
        end else if (!r_retry) begin
          r_hit_cnt <= sat_inc(r_hit_cnt);
        end
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: backing memory acks 2 cycles after each request.
// Counter checks are compiled in when DCACHE_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_rd_en = 1'b0;
  logic        cpu_wr_en = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_rd_en(cpu_rd_en),
    .cpu_wr_en(cpu_wr_en),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Backing memory: acks on the third negedge after the request appears (k=2).
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_we[$];
  int          wait_cnt = 0;
  int          rd_acks = 0;

  always @(negedge clk) begin
    if (!reset) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = mem_req ? 1 : 0;
    end else if (mem_req) begin
      wait_cnt++;
      if (wait_cnt == 3) begin
        mem_ack = 1'b1;
        log_addr.push_back(mem_addr);
        log_we.push_back(mem_we);
        log_data.push_back(mem_wdata);
        if (mem_we) begin
          mem_arr[mem_addr] = mem_wdata;
        end else begin
          mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'hBAD0_0000;
          rd_acks++;
        end
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int stalls, output logic [31:0] rdata);
    int n;
    cpu_rd_en = rd;
    cpu_wr_en = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    log_addr.delete();
    log_data.delete();
    log_we.delete();
    stalls = 0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
    end
    rdata = cpu_rdata;
    if (n == 200) check({name, " completes"}, 32'(stall), 32'd0);
    $display("txn %s addr=0x%08h stalls=%0d rdata=0x%08h", name, addr, stalls, rdata);
    @(posedge clk);
    #1;
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
  endtask

  initial begin
    int          st;
    int          n;
    int          base;
    logic [31:0] rd;
    logic [31:0] exp_wb [4];
    exp_wb = '{32'hA0, 32'hA1, 32'hDEAD, 32'hA3};

    for (int i = 0; i < 4; i++) begin
      mem_arr[32'h100 + 32'(4*i)] = 32'hA0 + 32'(i);
      mem_arr[32'h200 + 32'(4*i)] = 32'hB0 + 32'(i);
      mem_arr[32'h300 + 32'(4*i)] = 32'hC0 + 32'(i);
    end

    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst stall", 32'(stall), 32'd0);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst cpu_rdata", cpu_rdata, 32'd0);
`ifdef DCACHE_PERF_CNT_EN
    check("rst hit_cnt", hit_cnt, 32'd0);
    check("rst miss_cnt", miss_cnt, 32'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b1;

    // Clean miss: 4 words * 3 cycles + 1 detection cycle.
    access("ld 0x100", 1'b1, 1'b0, 32'h100, 32'h0, st, rd);
    check("ld100 stalls", 32'(st), 32'd13);
    check("ld100 rdata", rd, 32'hA0);
    check("ld100 nreq", 32'(log_addr.size()), 32'd4);
    for (int i = 0; i < log_addr.size(); i++) begin
      check($sformatf("ld100 addr%0d", i), log_addr[i], 32'h100 + 32'(4*i));
      check($sformatf("ld100 we%0d", i), 32'(log_we[i]), 32'd0);
    end

    access("ld 0x104", 1'b1, 1'b0, 32'h104, 32'h0, st, rd);
    check("ld104 stalls", 32'(st), 32'd0);
    check("ld104 rdata", rd, 32'hA1);

    access("st 0x108", 1'b0, 1'b1, 32'h108, 32'hDEAD, st, rd);
    check("st108 stalls", 32'(st), 32'd0);

    access("ld 0x108", 1'b1, 1'b0, 32'h108, 32'h0, st, rd);
    check("ld108 stalls", 32'(st), 32'd0);
    check("ld108 rdata", rd, 32'hDEAD);
`ifdef DCACHE_PERF_CNT_EN
    check("perf hit_cnt", hit_cnt, 32'd3);
    check("perf miss_cnt", miss_cnt, 32'd1);
`endif

    // Dirty miss: write-back then refill, 25 stall cycles.
    access("ld 0x200", 1'b1, 1'b0, 32'h200, 32'h0, st, rd);
    check("ld200 stalls", 32'(st), 32'd25);
    check("ld200 rdata", rd, 32'hB0);
    check("ld200 nreq", 32'(log_addr.size()), 32'd8);
    for (int i = 0; i < log_addr.size(); i++) begin
      if (i < 4) begin
        check($sformatf("wb addr%0d", i), log_addr[i], 32'h100 + 32'(4*i));
        check($sformatf("wb we%0d", i), 32'(log_we[i]), 32'd1);
        check($sformatf("wb data%0d", i), log_data[i], exp_wb[i]);
      end else begin
        check($sformatf("rf addr%0d", i-4), log_addr[i], 32'h200 + 32'(4*(i-4)));
        check($sformatf("rf we%0d", i-4), 32'(log_we[i]), 32'd0);
      end
    end
`ifdef DCACHE_PERF_CNT_EN
    check("perf2 miss_cnt", miss_cnt, 32'd2);
    check("perf2 hit_cnt", hit_cnt, 32'd3);
`endif

    // Reset asserted right after the second refill ack of a new miss.
    cpu_rd_en = 1'b1;
    cpu_addr  = 32'h300;
    base = rd_acks;
    for (n = 0; n < 200; n++) begin
      @(posedge clk);
      if (rd_acks == base + 2) break;
    end
    if (n == 200) check("mid wait acks", 32'(rd_acks - base), 32'd2);
    $display("txn ld 0x300 interrupted by reset after %0d refill acks", rd_acks - base);
    #1;
    reset     = 1'b0;
    cpu_rd_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid mem_req", 32'(mem_req), 32'd0);
    check("mid stall", 32'(stall), 32'd0);
    check("mid mem_addr", mem_addr, 32'd0);
`ifdef DCACHE_PERF_CNT_EN
    check("mid hit_cnt", hit_cnt, 32'd0);
    check("mid miss_cnt", miss_cnt, 32'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b1;

    access("reld 0x200", 1'b1, 1'b0, 32'h200, 32'h0, st, rd);
    check("reld200 stalls", 32'(st), 32'd13);
    check("reld200 rdata", rd, 32'hB0);
    check("reld200 nreq", 32'(log_addr.size()), 32'd4);
    if (log_addr.size() > 0) begin
      check("reld200 addr0", log_addr[0], 32'h200);
      check("reld200 we0", 32'(log_we[0]), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
